// File: rtl/dmem_pkg.sv
// Shared definitions for the tape data-memory responder and the select stages
// that talk to it.
package dmem_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int LD_LATENCY = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/dmem_ram.sv
// Tape RAM: one synchronous write port and one registered read port.
// A read and a write to the same word on the same edge return the old word.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Far end of the load/store chain: owns the tape RAM, zero-fills it after
// reset, returns loads with a fixed two-cycle latency and counts traffic.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW    = 12,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              busy,
    output logic              addr_err,
    output logic [CNT_W-1:0]  ld_count,
    output logic [CNT_W-1:0]  st_count
);

    dmem_state_t state, state_next;
    logic [AW-1:0] ptr, ptr_next;
    logic          clearing;

    logic ld_ok, st_ok, ld_take, st_take;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic          s1_valid, s1_oor;
    logic [AW-1:0] s1_addr;
    logic              s2_valid, s2_oor, s2_fwd;
    logic [DATA_W-1:0] s2_fwd_data;
    logic [DATA_W-1:0] ld_result, ld_hold;

    assign ld_ok   = (ld_addr >> AW) == '0;
    assign st_ok   = (st_addr >> AW) == '0;
    assign ld_take = (state == RUN) && ld_en;
    assign st_take = (state == RUN) && st_en && st_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clearing   = 1'b0;
        case (state)
            CLEAR: begin
                clearing = 1'b1;
                ptr_next = ptr + AW'(1);
                if (ptr == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign busy = clearing;

    // The zero-fill owns the write port while clearing; stores are dropped then.
    assign ram_we    = !rst && (clearing || st_take);
    assign ram_waddr = clearing ? ptr : st_addr[AW-1:0];
    assign ram_wdata = clearing ? '0 : st_data;

    dmem_ram #(
        .AW(AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(s1_addr),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_oor      <= 1'b0;
            s1_addr     <= '0;
            s2_valid    <= 1'b0;
            s2_oor      <= 1'b0;
            s2_fwd      <= 1'b0;
            s2_fwd_data <= '0;
        end else begin
            s1_valid    <= ld_take;
            s1_oor      <= !ld_ok;
            s1_addr     <= ld_addr[AW-1:0];
            s2_valid    <= s1_valid;
            s2_oor      <= s1_oor;
            // The RAM reads the old word on this edge, so a store landing now wins.
            s2_fwd      <= st_take && (st_addr[AW-1:0] == s1_addr);
            s2_fwd_data <= st_data;
        end
    end

    assign ld_result = s2_oor ? '0 : (s2_fwd ? s2_fwd_data : ram_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_hold <= '0;
        end else if (s2_valid) begin
            ld_hold <= ld_result;
        end
    end

    assign ld_data  = s2_valid ? ld_result : ld_hold;
    assign ld_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
            ld_count <= '0;
            st_count <= '0;
        end else begin
            addr_err <= (ld_en && !ld_ok) || (st_en && !st_ok);
            if (ld_take && ld_ok && ld_count != '1) begin
                ld_count <= ld_count + CNT_W'(1);
            end
            if (st_take && st_count != '1) begin
                st_count <= st_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a 16-word RAM and 4-bit counters so
// the zero-fill and counter saturation are quick to reach.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AW    = 4;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_en;
    logic [15:0]       ld_addr;
    logic              st_en;
    logic [15:0]       st_addr;
    logic [15:0]       st_data;
    logic [15:0]       ld_data;
    logic              ld_valid;
    logic              busy;
    logic              addr_err;
    logic [CNT_W-1:0]  ld_count;
    logic [CNT_W-1:0]  st_count;

    int checks = 0;
    int errors = 0;
    int n_ld   = 0;
    int n_st   = 0;

    dmem_responder #(
        .AW   (AW),
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .st_en   (st_en),
        .st_addr (st_addr),
        .st_data (st_data),
        .ld_data (ld_data),
        .ld_valid(ld_valid),
        .busy    (busy),
        .addr_err(addr_err),
        .ld_count(ld_count),
        .st_count(st_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ld_en = 1'b0;
        st_en = 1'b0;
    endtask

    // Drives one request cycle and tracks how many in-range requests were issued.
    task automatic drive(input logic le, input logic [15:0] la, input logic se,
                         input logic [15:0] sa, input logic [15:0] sd);
        ld_en   = le;
        ld_addr = la;
        st_en   = se;
        st_addr = sa;
        st_data = sd;
        if (le && la < 16'd16) n_ld++;
        if (se && sa < 16'd16) n_st++;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick;
        tick;
        n_ld = 0;
        n_st = 0;
        checks++; if (ld_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ld_data: got %h expected 0000", ld_data); end
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_valid: got %b expected 0", ld_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_err: got %b expected 0", addr_err); end
        checks++; if (ld_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_ld_count: got %0d expected 0", ld_count); end
        checks++; if (st_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_st_count: got %0d expected 0", st_count); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick;
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("[TB] FAIL clear_length: got %0d cycles expected 16", n); end
        drive(1'b1, 16'd5, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL ld5_early_valid: got %b expected 0", ld_valid); end
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h0000) begin errors++; $display("[TB] FAIL ld5_zero: got valid=%b data=%h expected 1/0000", ld_valid, ld_data); end
    endtask

    task automatic test_store_load;
        drive(1'b0, 16'h0, 1'b1, 16'd3, 16'h1234);
        tick;
        drive(1'b1, 16'd3, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h1234) begin errors++; $display("[TB] FAIL store_then_load: got valid=%b data=%h expected 1/1234", ld_valid, ld_data); end
    endtask

    task automatic test_forward;
        drive(1'b1, 16'd7, 1'b0, 16'h0, 16'h0);
        tick;
        drive(1'b0, 16'h0, 1'b1, 16'd7, 16'hBEEF);
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL forward_t1: got valid=%b data=%h expected 1/beef", ld_valid, ld_data); end
        drive(1'b0, 16'h0, 1'b1, 16'd7, 16'hCAFE);
        tick;
        idle;
        checks++; if (ld_valid !== 1'b0 || ld_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL forward_hold: got valid=%b data=%h expected 0/beef", ld_valid, ld_data); end
        drive(1'b1, 16'd7, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        tick;
        checks++; if (ld_data !== 16'hCAFE) begin errors++; $display("[TB] FAIL late_store_visible: got %h expected cafe", ld_data); end
    endtask

    task automatic test_same_cycle;
        drive(1'b1, 16'd9, 1'b1, 16'd9, 16'h00AA);
        tick;
        idle;
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h00AA) begin errors++; $display("[TB] FAIL same_cycle: got valid=%b data=%h expected 1/00aa", ld_valid, ld_data); end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 16'h0, 1'b1, 16'd1, 16'h0101);
        tick;
        drive(1'b0, 16'h0, 1'b1, 16'd2, 16'h0202);
        tick;
        drive(1'b1, 16'd1, 1'b0, 16'h0, 16'h0);
        tick;
        drive(1'b1, 16'd2, 1'b0, 16'h0, 16'h0);
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h0101) begin errors++; $display("[TB] FAIL b2b_first: got valid=%b data=%h expected 1/0101", ld_valid, ld_data); end
        drive(1'b1, 16'd3, 1'b0, 16'h0, 16'h0);
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h0202) begin errors++; $display("[TB] FAIL b2b_second: got valid=%b data=%h expected 1/0202", ld_valid, ld_data); end
        idle;
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h1234) begin errors++; $display("[TB] FAIL b2b_third: got valid=%b data=%h expected 1/1234", ld_valid, ld_data); end
        tick;
        checks++; if (ld_valid !== 1'b0 || ld_data !== 16'h1234) begin errors++; $display("[TB] FAIL b2b_idle_hold: got valid=%b data=%h expected 0/1234", ld_valid, ld_data); end
    endtask

    task automatic test_addr_range;
        drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        checks++; if (addr_err !== 1'b1 || ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL bad_ld_err: got err=%b valid=%b expected 1/0", addr_err, ld_valid); end
        tick;
        checks++; if (addr_err !== 1'b0 || ld_valid !== 1'b1 || ld_data !== 16'h0000) begin errors++; $display("[TB] FAIL bad_ld_return: got err=%b valid=%b data=%h expected 0/1/0000", addr_err, ld_valid, ld_data); end
        checks++; if (ld_count !== 4'd8) begin errors++; $display("[TB] FAIL bad_ld_count: got %0d expected 8", ld_count); end
        drive(1'b0, 16'h0, 1'b1, 16'h0020, 16'hFFFF);
        tick;
        idle;
        checks++; if (addr_err !== 1'b1 || st_count !== 4'd6) begin errors++; $display("[TB] FAIL bad_st: got err=%b st_count=%0d expected 1/6", addr_err, st_count); end
        drive(1'b1, 16'd0, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        tick;
        checks++; if (ld_data !== 16'h0000) begin errors++; $display("[TB] FAIL bad_st_untouched: got %h expected 0000", ld_data); end
        drive(1'b1, 16'h8003, 1'b1, 16'h0100, 16'h0005);
        tick;
        idle;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("[TB] FAIL dual_bad_pulse: got %b expected 1", addr_err); end
        tick;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL dual_bad_single: got %b expected 0", addr_err); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 1'b1, 16'd10, 16'h0A00 + 16'(i));
            tick;
        end
        idle;
        checks++; if (st_count !== 4'd14) begin errors++; $display("[TB] FAIL st_count_14: got %0d expected 14", st_count); end
        for (int i = 8; i < 12; i++) begin
            drive(1'b0, 16'h0, 1'b1, 16'd10, 16'h0A00 + 16'(i));
            tick;
        end
        idle;
        checks++; if (st_count !== 4'd15) begin errors++; $display("[TB] FAIL st_count_sat: got %0d expected 15", st_count); end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 16'd10, 1'b0, 16'h0, 16'h0);
            tick;
        end
        idle;
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h0A0B) begin errors++; $display("[TB] FAIL sat_last_load: got valid=%b data=%h expected 1/0a0b", ld_valid, ld_data); end
        checks++; if (ld_count !== 4'd15) begin errors++; $display("[TB] FAIL ld_count_sat: got %0d expected 15", ld_count); end
    endtask

    task automatic test_reset_mid;
        int  n;
        logic seen;
        drive(1'b1, 16'd3, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        rst = 1'b1;
        tick;
        rst  = 1'b0;
        n_ld = 0;
        n_st = 0;
        checks++; if (ld_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_flush: got valid=%b busy=%b expected 0/1", ld_valid, busy); end
        checks++; if (ld_count !== 4'd0 || st_count !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_counts: got ld=%0d st=%0d expected 0/0", ld_count, st_count); end
        n    = 0;
        seen = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            tick;
            n++;
            if (ld_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (n != 16) begin errors++; $display("[TB] FAIL reclear_length: got %0d cycles expected 16", n); end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL reclear_valid: got %b expected 0", seen); end
        drive(1'b1, 16'd3, 1'b0, 16'h0, 16'h0);
        tick;
        idle;
        tick;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 16'h0000) begin errors++; $display("[TB] FAIL rezeroed: got valid=%b data=%h expected 1/0000", ld_valid, ld_data); end
        checks++; if (ld_count !== 4'd1) begin errors++; $display("[TB] FAIL post_reset_count: got %0d expected 1", ld_count); end
    endtask

    initial begin
        $display("[TB] dmem_responder bench start");
        test_reset;
        test_store_load;
        test_forward;
        test_same_cycle;
        test_back_to_back;
        test_addr_range;
        test_saturation;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
